// File: rtl/button_event.sv
// button_event: synchronised press/release/hold pulses, auto-repeat when BUTTON_EVENT_REPEAT_EN is defined
module button_event #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic BTN_press,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
`ifdef BUTTON_EVENT_REPEAT_EN
  output logic repeat_pulse,
`endif
  output logic held
);
  localparam int MAX_CYCLES = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int W = $clog2(MAX_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  state_t state, state_n;
  logic s1, s2;
  logic [W-1:0] cnt, cnt_n;
  logic press_n, release_n, hold_n;
`ifdef BUTTON_EVENT_REPEAT_EN
  logic repeat_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    press_n = 1'b0;
    release_n = 1'b0;
    hold_n = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    repeat_n = 1'b0;
`endif
    if (state == IDLE) begin
      if (s2) begin
        state_n = PRESSED;
        press_n = 1'b1;
        cnt_n = '0;
      end
    end else if (!s2) begin
      state_n = IDLE;
      release_n = 1'b1;
      cnt_n = '0;
    end else if (state == PRESSED) begin
      hold_n = cnt == W'(HOLD_CYCLES - 1);
      state_n = hold_n ? HELD : PRESSED;
      cnt_n = hold_n ? '0 : cnt + 1'b1;
    end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_n = cnt == W'(REPEAT_CYCLES - 1);
      cnt_n = repeat_n ? '0 : cnt + 1'b1;
`else
      cnt_n = '0;
`endif
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_pulse <= 1'b0;
`endif
      held <= 1'b0;
    end else begin
      s1 <= BTN_press;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
      press_pulse <= press_n;
      release_pulse <= release_n;
      hold_pulse <= hold_n;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_pulse <= repeat_n;
`endif
      held <= state_n != IDLE;
    end
  end
endmodule
